// File: rtl/tlul_host_rr_arbiter.sv
// Round-robin arbiter sharing one TL-UL host adapter between N_HOST req/gnt agents.
// An in-order ID FIFO steers each adapter response back to the agent that issued it.
module tlul_host_rr_arbiter #(
    parameter int N_HOST    = 2,
    parameter int MAX_OUTST = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_HOST-1:0]     req_i,
    output logic [N_HOST-1:0]     gnt_o,
    input  logic [N_HOST*32-1:0]  addr_i,
    input  logic [N_HOST-1:0]     we_i,
    input  logic [N_HOST*32-1:0]  wdata_i,
    input  logic [N_HOST*4-1:0]   be_i,
    output logic [N_HOST-1:0]     valid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic                  req_o,
    input  logic                  gnt_i,
    output logic [31:0]           addr_o,
    output logic                  we_o,
    output logic [31:0]           wdata_o,
    output logic [3:0]            be_o,
    input  logic                  valid_i,
    input  logic [31:0]           rdata_i,
    input  logic                  err_i,
    output logic                  spur_o
);

    localparam int IDW = (N_HOST > 1) ? $clog2(N_HOST) : 1;
    localparam int SW  = IDW + 1;
    localparam int PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW  = $clog2(MAX_OUTST + 1);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] lock_id;
    logic           lock;
    logic [IDW-1:0] scan_sel;
    logic [SW-1:0]  scan_idx;
    logic           found;
    logic [IDW-1:0] sel;

    logic [IDW-1:0] id_mem [MAX_OUTST];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    // Scan for the first requester starting at rr_ptr, wrapping mod N_HOST.
    always_comb begin
        scan_sel = rr_ptr;
        scan_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < N_HOST; i++) begin
            scan_idx = {1'b0, rr_ptr} + SW'(i);
            if (scan_idx >= SW'(N_HOST)) begin
                scan_idx = scan_idx - SW'(N_HOST);
            end
            if (!found && req_i[scan_idx[IDW-1:0]]) begin
                found    = 1'b1;
                scan_sel = scan_idx[IDW-1:0];
            end
        end
    end

    assign sel   = lock ? lock_id : scan_sel;
    assign full  = (count == CW'(MAX_OUTST));
    assign empty = (count == '0);

    // Handshake: a request transfers on a cycle where req_o and gnt_i are both high;
    // once req_o is raised, the selected agent and its fields stay put until then.
    assign req_o = (|req_i) & ~full;
    assign push  = req_o & gnt_i;
    assign pop   = valid_i & ~empty;

    assign addr_o  = addr_i[{sel, 5'b0} +: 32];
    assign wdata_o = wdata_i[{sel, 5'b0} +: 32];
    assign be_o    = be_i[{sel, 2'b0} +: 4];
    assign we_o    = we_i[sel];
    assign rdata_o = rdata_i;
    assign err_o   = err_i;

    always_comb begin
        gnt_o   = '0;
        valid_o = '0;
        if (push) begin
            gnt_o[sel] = 1'b1;
        end
        if (pop) begin
            valid_o[id_mem[rd_ptr]] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr  <= '0;
            lock    <= 1'b0;
            lock_id <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            spur_o  <= 1'b0;
        end else begin
            spur_o <= valid_i & empty;
            if (push) begin
                lock   <= 1'b0;
                rr_ptr <= (sel == IDW'(N_HOST - 1)) ? '0 : sel + 1'b1;
                wr_ptr <= (wr_ptr == PW'(MAX_OUTST - 1)) ? '0 : wr_ptr + 1'b1;
            end else if (req_o) begin
                lock    <= 1'b1;
                lock_id <= sel;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(MAX_OUTST - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr] <= sel;
        end
    end

endmodule

// File: tb/tb_tlul_host_rr_arbiter.sv
// Bench for tlul_host_rr_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based model of arbitration and response routing.
module tb_tlul_host_rr_arbiter;

    localparam int N = 2;
    localparam int M = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    gnt_o;
    logic [N*32-1:0] addr_bus;
    logic [N-1:0]    we_bus;
    logic [N*32-1:0] wdata_bus;
    logic [N*4-1:0]  be_bus;
    logic [N-1:0]    valid_o;
    logic [31:0]     rdata_o;
    logic            err_o;
    logic            req_o;
    logic            gnt_in;
    logic [31:0]     addr_o;
    logic            we_o;
    logic [31:0]     wdata_o;
    logic [3:0]      be_o;
    logic            valid_in;
    logic [31:0]     rdata_in;
    logic            err_in;
    logic            spur_o;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: queue of issuing agents, next-priority agent, pending (locked) agent.
    logic [7:0] exp_q[$];
    int         m_rr;
    int         m_pend;
    bit         m_spur;

    tlul_host_rr_arbiter #(.N_HOST(N), .MAX_OUTST(M)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .gnt_o(gnt_o),
        .addr_i(addr_bus), .we_i(we_bus), .wdata_i(wdata_bus), .be_i(be_bus),
        .valid_o(valid_o), .rdata_o(rdata_o), .err_o(err_o),
        .req_o(req_o), .gnt_i(gnt_in),
        .addr_o(addr_o), .we_o(we_o), .wdata_o(wdata_o), .be_o(be_o),
        .valid_i(valid_in), .rdata_i(rdata_in), .err_i(err_in),
        .spur_o(spur_o)
    );

    always #5 clk = ~clk;

    task automatic rand_fields();
        addr_bus  = {$urandom, $urandom};
        wdata_bus = {$urandom, $urandom};
        we_bus    = N'($urandom_range(0, 3));
        be_bus    = 8'($urandom_range(0, 255));
    endtask

    // Drive one cycle of inputs at the falling edge, then settle before sampling.
    task automatic cyc(input logic [N-1:0] r, input logic g, input logic v,
                       input logic [31:0] rd, input logic e);
        @(negedge clk);
        req      = r;
        gnt_in   = g;
        valid_in = v;
        rdata_in = rd;
        err_in   = e;
        rand_fields();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0; gnt_in = 1'b0; valid_in = 1'b0; rdata_in = '0; err_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_rr   = 0;
        m_pend = -1;
        m_spur = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0; gnt_in = 1'b0; valid_in = 1'b1; rdata_in = '0; err_in = 1'b0;
        rand_fields();
        @(negedge clk);
        #1;
        n_chk++; if (req_o !== 1'b0) $display("FAIL reset_req_o got %b want 0", req_o); else n_pass++;
        n_chk++; if (gnt_o !== 2'b00) $display("FAIL reset_gnt_o got %b want 00", gnt_o); else n_pass++;
        n_chk++; if (spur_o !== 1'b0) $display("FAIL reset_spur_o got %b want 0", spur_o); else n_pass++;
        do_reset();
        #1;
        n_chk++; if (valid_o !== 2'b00) $display("FAIL reset_valid_o got %b want 00", valid_o); else n_pass++;
    endtask

    task automatic test_single_agent();
        logic [31:0] rd;
        do_reset();
        cyc(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
        n_chk++; if (gnt_o !== 2'b10) $display("FAIL single_gnt got %b want 10", gnt_o); else n_pass++;
        n_chk++; if (addr_o !== addr_bus[63:32]) $display("FAIL single_addr got %h want %h", addr_o, addr_bus[63:32]); else n_pass++;
        cyc(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        rd = $urandom;
        cyc(2'b00, 1'b0, 1'b1, rd, 1'b0);
        n_chk++; if (valid_o !== 2'b10) $display("FAIL single_valid got %b want 10", valid_o); else n_pass++;
        n_chk++; if (rdata_o !== rd) $display("FAIL single_rdata got %h want %h", rdata_o, rd); else n_pass++;
    endtask

    task automatic test_alternate();
        logic [N-1:0] want_g;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(2'b11, 1'b1, (i > 0), $urandom, 1'b0);
            want_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_chk++; if (gnt_o !== want_g) $display("FAIL alt_gnt[%0d] got %b want %b", i, gnt_o, want_g); else n_pass++;
            if (i > 0) begin
                n_chk++; if (valid_o !== ~want_g) $display("FAIL alt_valid[%0d] got %b want %b", i, valid_o, ~want_g); else n_pass++;
            end
        end
    endtask

    task automatic test_lock();
        do_reset();
        cyc(2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
        n_chk++; if (addr_o !== addr_bus[63:32]) $display("FAIL lock_addr0 got %h want %h", addr_o, addr_bus[63:32]); else n_pass++;
        for (int i = 1; i < 3; i++) begin
            cyc(2'b11, 1'b0, 1'b0, 32'h0, 1'b0);
            n_chk++; if (addr_o !== addr_bus[63:32]) $display("FAIL lock_addr%0d got %h want %h", i, addr_o, addr_bus[63:32]); else n_pass++;
            n_chk++; if (gnt_o !== 2'b00) $display("FAIL lock_nogrant%0d got %b want 00", i, gnt_o); else n_pass++;
        end
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        n_chk++; if (gnt_o !== 2'b10) $display("FAIL lock_first_gnt got %b want 10", gnt_o); else n_pass++;
        cyc(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        n_chk++; if (gnt_o !== 2'b01) $display("FAIL lock_second_gnt got %b want 01", gnt_o); else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        cyc(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        n_chk++; if (gnt_o !== 2'b01) $display("FAIL full_second_gnt got %b want 01", gnt_o); else n_pass++;
        cyc(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        n_chk++; if (req_o !== 1'b0) $display("FAIL full_req_blocked got %b want 0", req_o); else n_pass++;
        n_chk++; if (gnt_o !== 2'b00) $display("FAIL full_gnt_blocked got %b want 00", gnt_o); else n_pass++;
        cyc(2'b01, 1'b1, 1'b1, 32'h0, 1'b0);
        n_chk++; if (req_o !== 1'b0) $display("FAIL full_pop_same_cycle got %b want 0", req_o); else n_pass++;
        n_chk++; if (valid_o !== 2'b01) $display("FAIL full_pop_valid got %b want 01", valid_o); else n_pass++;
        cyc(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        n_chk++; if (req_o !== 1'b1) $display("FAIL full_reenable got %b want 1", req_o); else n_pass++;
        n_chk++; if (gnt_o !== 2'b01) $display("FAIL full_reenable_gnt got %b want 01", gnt_o); else n_pass++;
    endtask

    task automatic test_err();
        do_reset();
        cyc(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
        n_chk++; if (gnt_o !== 2'b10) $display("FAIL err_gnt_a1 got %b want 10", gnt_o); else n_pass++;
        cyc(2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
        n_chk++; if ({valid_o, err_o} !== 3'b010) $display("FAIL err_resp0 got %b want 010", {valid_o, err_o}); else n_pass++;
        cyc(2'b00, 1'b0, 1'b1, 32'h0, 1'b1);
        n_chk++; if ({valid_o, err_o} !== 3'b101) $display("FAIL err_resp1 got %b want 101", {valid_o, err_o}); else n_pass++;
    endtask

    task automatic test_spurious();
        do_reset();
        cyc(2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
        n_chk++; if (valid_o !== 2'b00) $display("FAIL spur_valid got %b want 00", valid_o); else n_pass++;
        cyc(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        n_chk++; if (spur_o !== 1'b1) $display("FAIL spur_pulse got %b want 1", spur_o); else n_pass++;
        cyc(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        n_chk++; if (spur_o !== 1'b0) $display("FAIL spur_clear got %b want 0", spur_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        do_reset();
        cyc(2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
        n_chk++; if (valid_o !== 2'b00) $display("FAIL midrst_valid got %b want 00", valid_o); else n_pass++;
        cyc(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        n_chk++; if (spur_o !== 1'b1) $display("FAIL midrst_spur got %b want 1", spur_o); else n_pass++;
    endtask

    task automatic test_random();
        logic [N-1:0] r, e_gnt, e_valid;
        int           sel, idx;
        bit           full, e_req, hs;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r = N'($urandom_range(0, 3));
            if (m_pend >= 0) r[m_pend] = 1'b1;
            cyc(r, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4), $urandom, 1'($urandom_range(0, 1)));
            full = (exp_q.size() == M);
            sel  = m_pend;
            if (sel < 0) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (sel < 0 && r[idx]) sel = idx;
                end
            end
            e_req   = (r != 0) && !full;
            hs      = e_req && gnt_in;
            e_gnt   = '0;
            e_valid = '0;
            if (hs) e_gnt[sel] = 1'b1;
            if (valid_in && exp_q.size() > 0) e_valid[exp_q[0]] = 1'b1;
            n_chk++; if (req_o !== e_req) $display("FAIL rnd_req_o c=%0d got %b want %b", c, req_o, e_req); else n_pass++;
            n_chk++; if (gnt_o !== e_gnt) $display("FAIL rnd_gnt_o c=%0d got %b want %b", c, gnt_o, e_gnt); else n_pass++;
            n_chk++; if (valid_o !== e_valid) $display("FAIL rnd_valid_o c=%0d got %b want %b", c, valid_o, e_valid); else n_pass++;
            n_chk++; if (spur_o !== m_spur) $display("FAIL rnd_spur_o c=%0d got %b want %b", c, spur_o, m_spur); else n_pass++;
            n_chk++; if (rdata_o !== rdata_in) $display("FAIL rnd_rdata c=%0d got %h want %h", c, rdata_o, rdata_in); else n_pass++;
            if (e_req) begin
                n_chk++;
                if ({addr_o, we_o, wdata_o, be_o} !== {addr_bus[sel*32 +: 32], we_bus[sel], wdata_bus[sel*32 +: 32], be_bus[sel*4 +: 4]})
                    $display("FAIL rnd_fields c=%0d got %h/%b/%h/%h want agent %0d", c, addr_o, we_o, wdata_o, be_o, sel);
                else n_pass++;
            end
            if (e_valid != 0) begin
                n_chk++; if (err_o !== err_in) $display("FAIL rnd_err c=%0d got %b want %b", c, err_o, err_in); else n_pass++;
            end
            m_spur = valid_in && (exp_q.size() == 0);
            if (valid_in && exp_q.size() > 0) void'(exp_q.pop_front());
            if (hs) begin
                exp_q.push_back(8'(sel));
                m_rr   = (sel + 1) % N;
                m_pend = -1;
            end else if (e_req) begin
                m_pend = sel;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_agent();
        test_alternate();
        test_lock();
        test_full();
        test_err();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
